// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants: the eight initial hash words, the packed 256-bit IV
// and the state encoding of the digest accumulator.
package sha256_pkg;

  localparam logic [31:0] IvA = 32'h6a09e667;
  localparam logic [31:0] IvB = 32'hbb67ae85;
  localparam logic [31:0] IvC = 32'h3c6ef372;
  localparam logic [31:0] IvD = 32'ha54ff53a;
  localparam logic [31:0] IvE = 32'h510e527f;
  localparam logic [31:0] IvF = 32'h9b05688c;
  localparam logic [31:0] IvG = 32'h1f83d9ab;
  localparam logic [31:0] IvH = 32'h5be0cd19;

  // Word A in the most significant slot, H in the least.
  localparam logic [255:0] Sha256Iv = {IvA, IvB, IvC, IvD, IvE, IvF, IvG, IvH};

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StHold  = 2'd2
  } state_e;

endpackage

// File: rtl/sha256_word_add8.sv
// Eight independent 32-bit modulo-2^32 adders over packed 256-bit vectors;
// no carry crosses a word boundary.
module sha256_word_add8 (
  input  logic [255:0] a_i,
  input  logic [255:0] b_i,
  output logic [255:0] sum_o
);

  for (genvar i = 0; i < 8; i++) begin : g_word
    assign sum_o[i*32 +: 32] = a_i[i*32 +: 32] + b_i[i*32 +: 32];
  end

endmodule

// File: rtl/sha256_digest_accum.sv
// SHA-256 feed-forward accumulator: adds each compressed block onto the chaining
// value and presents the final digest. Optional protocol check: SHA256_ROUND_CHECK_EN.
module sha256_digest_accum
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_first,
  input  logic         in_last,
  input  logic [5:0]   round_in,
  input  logic [255:0] hash_middle_in,
  output logic [255:0] chain_out,
  output logic [255:0] digest,
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic [15:0]  blk_cnt,
  output logic         round_err
);

  state_e        state_q, state_d;
  logic [255:0]  chain_q, chain_d;
  logic [255:0]  digest_q, digest_d;
  logic          dvalid_q, dvalid_d;
  logic [15:0]   cnt_q, cnt_d;

  logic          accept;
  logic          use_iv;
  logic [255:0]  base;
  logic [255:0]  sum;

  assign in_ready = (state_q != StHold) || digest_ready;
  assign accept   = in_valid && in_ready;
  assign use_iv   = in_first || (state_q == StIdle);
  assign base     = use_iv ? Sha256Iv : chain_q;

  sha256_word_add8 u_add (
    .a_i   (base),
    .b_i   (hash_middle_in),
    .sum_o (sum)
  );

  always_comb begin
    state_d  = state_q;
    chain_d  = chain_q;
    digest_d = digest_q;
    dvalid_d = dvalid_q;
    cnt_d    = cnt_q;
    if (accept) begin
      chain_d  = sum;
      cnt_d    = use_iv ? 16'd1 : ((cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1);
      dvalid_d = in_last;
      if (in_last) begin
        digest_d = sum;
        state_d  = StHold;
      end else begin
        state_d  = StAccum;
      end
    end else if ((state_q == StHold) && digest_ready) begin
      // Consumer took the digest; the value itself stays visible.
      dvalid_d = 1'b0;
      state_d  = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      chain_q  <= Sha256Iv;
      digest_q <= '0;
      dvalid_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      chain_q  <= chain_d;
      digest_q <= digest_d;
      dvalid_q <= dvalid_d;
      cnt_q    <= cnt_d;
    end
  end

  assign chain_out    = chain_q;
  assign digest       = digest_q;
  assign digest_valid = dvalid_q;
  assign blk_cnt      = cnt_q;

`ifdef SHA256_ROUND_CHECK_EN
  logic err_q, err_d;

  // Sticky: a block arriving mid-round or a continuation with no open message.
  always_comb begin
    err_d = err_q;
    if (accept && ((round_in != 6'd0) || (!in_first && (state_q == StIdle)))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign round_err = err_q;
`else
  logic unused_round;
  assign unused_round = ^round_in;
  assign round_err    = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_digest_accum.sv
// Self-checking bench for sha256_digest_accum: directed vector table, hand-written
// corner sequences and randomized traffic against a word-level reference model.
module tb_sha256_digest_accum;

  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
`ifdef SHA256_ROUND_CHECK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_first = 1'b0;
  logic         in_last = 1'b0;
  logic         digest_ready = 1'b0;
  logic [5:0]   round_in = '0;
  logic [255:0] hash_middle_in = '0;
  logic         in_ready;
  logic [255:0] chain_out;
  logic [255:0] digest;
  logic         digest_valid;
  logic [15:0]  blk_cnt;
  logic         round_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: message open / digest pending flags and word arrays.
  logic [255:0] m_chain;
  logic [255:0] m_digest;
  logic         m_pending;
  logic         m_open;
  int           m_cnt;
  logic         m_err;

  sha256_digest_accum dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_first       (in_first),
    .in_last        (in_last),
    .round_in       (round_in),
    .hash_middle_in (hash_middle_in),
    .chain_out      (chain_out),
    .digest         (digest),
    .digest_valid   (digest_valid),
    .digest_ready   (digest_ready),
    .blk_cnt        (blk_cnt),
    .round_err      (round_err)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] add_words(input logic [255:0] a, input logic [255:0] b);
    logic [255:0] r;
    logic [31:0]  w;
    for (int i = 0; i < 8; i++) begin
      w = a[i*32 +: 32] + b[i*32 +: 32];
      r[i*32 +: 32] = w;
    end
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".chain_out"}, chain_out, m_chain);
    chk({tag, ".digest"}, digest, m_digest);
    chk({tag, ".digest_valid"}, {255'd0, digest_valid}, {255'd0, m_pending});
    chk({tag, ".blk_cnt"}, {240'd0, blk_cnt}, 256'(m_cnt));
    chk({tag, ".round_err"}, {255'd0, round_err}, {255'd0, m_err});
  endtask

  task automatic model_reset();
    m_chain   = IV;
    m_digest  = '0;
    m_pending = 1'b0;
    m_open    = 1'b0;
    m_cnt     = 0;
    m_err     = 1'b0;
  endtask

  // One clock with the inputs currently driven; call at posedge+1.
  task automatic cycle(input string tag);
    logic         ready, acc, fresh, idle;
    logic [255:0] s;
    #1;
    ready = !m_pending || digest_ready;
    chk({tag, ".in_ready"}, {255'd0, in_ready}, {255'd0, ready});
    idle  = !m_open && !m_pending;
    acc   = in_valid && ready;
    fresh = in_first || idle;
    s     = add_words(fresh ? IV : m_chain, hash_middle_in);
    @(posedge clk);
    if (acc) begin
      if (ERR_ON && ((round_in != 6'd0) || (!in_first && idle))) m_err = 1'b1;
      m_chain = s;
      m_cnt   = fresh ? 1 : ((m_cnt >= 65535) ? 65535 : m_cnt + 1);
      if (in_last) begin
        m_digest  = s;
        m_pending = 1'b1;
        m_open    = 1'b0;
      end else begin
        m_pending = 1'b0;
        m_open    = 1'b1;
      end
    end else if (m_pending && digest_ready) begin
      m_pending = 1'b0;
    end
    #1;
    check_outputs(tag);
  endtask

  // Asserts reset away from any clock edge, checks the effect immediately.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    chk({tag, ".chain_iv"}, chain_out, IV);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         first;
    logic         last;
    logic         dready;
    logic [255:0] hm;
    logic [255:0] exp_chain;
    logic [255:0] exp_digest;
    logic         exp_dv;
    logic [15:0]  exp_cnt;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [255:0] hm_h1;
    logic [255:0] hm_a;
    logic [255:0] saved;
    logic [255:0] hm;
    logic [255:0] d_row2;

    hm_h1 = 256'd1;
    hm_a  = {32'h95f61999, 224'd0};
    d_row2 = {32'h00000000, IV[223:0]};
    vecs[0] = '{1'b1, 1'b1, 1'b0, 256'd0, IV, IV, 1'b1, 16'd1};
    vecs[1] = '{1'b1, 1'b1, 1'b1, hm_a, d_row2, d_row2, 1'b1, 16'd1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, hm_h1, {IV[255:32], 32'h5be0cd1a}, d_row2, 1'b0, 16'd1};
    vecs[3] = '{1'b0, 1'b1, 1'b0, hm_h1, {IV[255:32], 32'h5be0cd1b},
                {IV[255:32], 32'h5be0cd1b}, 1'b1, 16'd2};

    apply_reset("reset");

    for (int i = 0; i < 4; i++) begin
      in_valid       = 1'b1;
      in_first       = vecs[i].first;
      in_last        = vecs[i].last;
      digest_ready   = vecs[i].dready;
      hash_middle_in = vecs[i].hm;
      round_in       = 6'd0;
      cycle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_chain", i), chain_out, vecs[i].exp_chain);
      chk($sformatf("vec%0d.tbl_digest", i), digest, vecs[i].exp_digest);
      chk($sformatf("vec%0d.tbl_dv", i), {255'd0, digest_valid}, {255'd0, vecs[i].exp_dv});
      chk($sformatf("vec%0d.tbl_cnt", i), {240'd0, blk_cnt}, {240'd0, vecs[i].exp_cnt});
    end

    // Back-pressure in HOLD, then release with a simultaneous new first block.
    saved          = digest;
    hm             = rand256();
    in_valid       = 1'b1;
    in_first       = 1'b1;
    in_last        = 1'b0;
    digest_ready   = 1'b0;
    hash_middle_in = hm;
    for (int i = 0; i < 5; i++) begin
      cycle("hold");
      chk("hold.in_ready_low", {255'd0, in_ready}, 256'd0);
      chk("hold.digest_stable", digest, saved);
    end
    digest_ready = 1'b1;
    cycle("release");
    chk("release.chain", chain_out, add_words(IV, hm));
    chk("release.cnt", {240'd0, blk_cnt}, 256'd1);
    chk("release.dv", {255'd0, digest_valid}, 256'd0);

    // Reset mid-message, then a continuation block must still start from IV.
    apply_reset("mid_reset");
    hm       = rand256();
    in_valid = 1'b1;
    in_first = 1'b0;
    in_last  = 1'b0;
    hash_middle_in = hm;
    cycle("after_reset");
    chk("after_reset.chain", chain_out, add_words(IV, hm));
    chk("after_reset.cnt", {240'd0, blk_cnt}, 256'd1);

    // Non-zero round counter on accept.
    apply_reset("err_reset");
    in_valid = 1'b1;
    in_first = 1'b1;
    in_last  = 1'b1;
    round_in = 6'd5;
    hash_middle_in = '0;
    cycle("round5");
    chk("round5.err", {255'd0, round_err}, {255'd0, ERR_ON});
    in_valid = 1'b0;
    round_in = 6'd0;
    digest_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle("round5_idle");
    chk("round5.err_sticky", {255'd0, round_err}, {255'd0, ERR_ON});
    apply_reset("err_clear");

    for (int i = 0; i < 400; i++) begin
      in_valid       = ($urandom % 4) != 0;
      in_first       = ($urandom % 4) == 0;
      in_last        = ($urandom % 3) == 0;
      digest_ready   = ($urandom % 2) == 0;
      round_in       = (($urandom % 16) == 0) ? 6'($urandom) : 6'd0;
      hash_middle_in = rand256();
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sha256_digest_accum.md
SHA256_DIGEST_ACCUM -- requirements
Module: sha256_digest_accum

Interface
REQ-001 The block SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL provide port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL provide port in_valid, input, 1 bit: a compressed block is presented.
REQ-004 The block SHALL provide port in_ready, output, 1 bit: the block can accept input this cycle.
REQ-005 The block SHALL provide port in_first, input, 1 bit: the presented block is the first block of a message.
REQ-006 The block SHALL provide port in_last, input, 1 bit: the presented block is the last block of a message.
REQ-007 The block SHALL provide port round_in, input, 6 bits: round counter from the final round stage; it is 6'd0 after the wrap past 63.
REQ-008 The block SHALL provide port hash_middle_in, input, 256 bits: working variables after 64 rounds, A in [255:224] down to H in [31:0].
REQ-009 The block SHALL provide port chain_out, output, 256 bits: current chaining value, same word order, seeding the next block's rounds.
REQ-010 The block SHALL provide port digest, output, 256 bits: final message digest.
REQ-011 The block SHALL provide port digest_valid, output, 1 bit: digest holds a result.
REQ-012 The block SHALL provide port digest_ready, input, 1 bit: the consumer takes the digest.
REQ-013 The block SHALL provide port blk_cnt, output, 16 bits: blocks accepted in the current message.
REQ-014 The block SHALL provide port round_err, output, 1 bit: sticky protocol error flag.

Function
REQ-015 The block SHALL implement three states: IDLE (no message open), ACCUM (message open, not last), HOLD (digest waiting).
REQ-016 The block SHALL drive in_ready = (state != HOLD) || digest_ready.
REQ-017 The block SHALL accept an input block when in_valid && in_ready, at that rising edge.
REQ-018 On accept, the block SHALL form a sum word-wise: base word + hash_middle_in word, modulo 2^32, with no carry between words.
REQ-019 The base SHALL be the sha256 IV when in_first=1 or state is IDLE, otherwise chain_out.
REQ-020 On accept, the block SHALL register the sum into chain_out; result latency is one clock.
REQ-021 On accept with in_last=0, the block SHALL go to ACCUM.
REQ-022 On accept with in_last=1, the block SHALL load digest with the sum, set digest_valid=1, and go to HOLD.
REQ-023 When in_first=1 and in_last=1 together, the block SHALL treat the input as a single-block message: IV base, straight to HOLD.
REQ-024 In HOLD with digest_ready=1 and no accept, the block SHALL clear digest_valid next cycle and go to IDLE; digest keeps its value.
REQ-025 In HOLD with digest_ready=1 and a simultaneous accept, the block SHALL apply the accept rules and take the resulting state; digest_valid stays 1 only if that accept had in_last=1.
REQ-026 On an in_first accept while in ACCUM, the block SHALL abandon the open message and restart from IV.
REQ-027 On each accept, blk_cnt SHALL load 1 if IV base is used, else increment, saturating at 16'hFFFF.
REQ-028 Signals outside an accept cycle SHALL be ignored, with no state change from inputs.

Reset
REQ-029 While rst_n=0, the block SHALL asynchronously force: state=IDLE, chain_out=IV, digest=0, digest_valid=0, blk_cnt=0, round_err=0.
REQ-030 Reset mid-message or in HOLD SHALL discard all progress; the first accept after reset uses IV.

Configuration
REQ-031 With SHA256_ROUND_CHECK_EN defined, the block SHALL set round_err on an accept where round_in != 6'd0, or where in_first=0 while in IDLE; the flag clears only on reset.
REQ-032 Without SHA256_ROUND_CHECK_EN, the block SHALL tie round_err to 0 and synthesise no check logic; all other behaviour is unchanged.

Structure
REQ-033 The eight IV words and the 256-bit IV constant SHALL live in the shared package sha256_pkg, together with the state encoding.
REQ-034 The block SHALL instantiate one sub-module, sha256_word_add8: combinational, 8 parallel 32-bit modulo adds on 256-bit vectors.

Verification
REQ-035 The bench SHALL check: reset, then a single block with first=last=1, hash_middle_in=0 -> digest=6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19 one cycle later, blk_cnt=1.
REQ-036 The bench SHALL check: word A=95f61999, other words 0 -> digest word A=00000000 (wrap, no carry into word B=bb67ae85).
REQ-037 The bench SHALL check: two-block message, block1 first, block2 last, each with hash_middle_in word H=1 -> digest word H = 5be0cd19+2 = 5be0cd1b, blk_cnt=2.
REQ-038 The bench SHALL check: HOLD with digest_ready=0 for 5 cycles -> in_ready=0 and digest stable; then digest_ready=1 together with in_valid, first=1 -> accepted that same cycle.
REQ-039 The bench SHALL check: rst_n pulsed low in ACCUM -> all outputs at reset values at once, and the next accept uses IV.
REQ-040 The bench SHALL check, with SHA256_ROUND_CHECK_EN defined: round_in=6'd5 on accept -> round_err=1 and it stays set until reset.
